// File: rtl/tone_period_meter.sv
// tone_period_meter: measures the rising-edge-to-rising-edge period of an
// asynchronous square wave in system clock cycles. The input is synchronized,
// edge-detected, and timed by a saturating counter run by a three-state FSM.
// All outputs come straight from flops.
module tone_period_meter #(
    parameter int CNT_WIDTH   = 20,
    parameter int SYNC_STAGES = 2    // legal range 2..3
) (
    input  logic                 clock,
    input  logic                 reset,      // asynchronous, active-low
    input  logic                 tone_in,    // asynchronous square wave
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] period,
    output logic                 period_valid,
    output logic                 timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    // Synchronizer chain and edge-history flop
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   rise;

    // Measurement state
    state_t                 state_q, state_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   timeout_q, timeout_d;

    // Shift tone_in through the synchronizer; the history flop holds the
    // previous synchronized sample so a rise is a 0->1 step between them.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tone_in};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    // Next-state, counter and output computation for the IDLE/ARM/MEASURE FSM
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;

        if (!enable) begin
            // Dropping enable wins over everything, including a coincident
            // rise: no pulse, period keeps its last value.
            state_d   = IDLE;
            cnt_d     = CNT_ZERO;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = CNT_ZERO;
                    state_d = ARM;
                end
                ARM: begin
                    // First rise only starts the count; there is no
                    // reference edge yet, so no period can be reported.
                    if (rise) begin
                        cnt_d   = CNT_ONE;
                        state_d = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        // A rise at the all-ones count is still a valid
                        // measurement; it is checked before saturation.
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        // Counter would wrap: flag it and wait for a fresh
                        // arming edge instead.
                        timeout_d = 1'b1;
                        cnt_d     = CNT_ZERO;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Register everything; reset clears the whole datapath including the
    // synchronizer so a partial count or stale edge cannot survive it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q    <= '0;
            hist_q    <= 1'b0;
            state_q   <= IDLE;
            cnt_q     <= CNT_ZERO;
            period_q  <= CNT_ZERO;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            hist_q    <= hist_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Directed bench for tone_period_meter: one default-width instance (A) and
// one CNT_WIDTH=4 instance (B) for saturation cases, sharing clock and reset.
module tb_tone_period_meter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        tin_a = 1'b0, en_a = 1'b0;
    logic        tin_b = 1'b0, en_b = 1'b0;
    logic [19:0] period_a;
    logic [3:0]  period_b;
    logic        valid_a, valid_b, tmo_a, tmo_b;

    int n_cmp = 0;
    int n_err = 0;

    // Observation counters, sampled 1 time unit after each rising edge
    int cyc = 0;
    int a_edges = 0, a_high = 0, a_last = 0, a_gap = 0;
    int b_edges = 0;
    logic a_prev = 1'b0, b_prev = 1'b0;

    tone_period_meter u_a (
        .clock(clock), .reset(reset), .tone_in(tin_a), .enable(en_a),
        .period(period_a), .period_valid(valid_a), .timeout(tmo_a)
    );

    tone_period_meter #(.CNT_WIDTH(4), .SYNC_STAGES(2)) u_b (
        .clock(clock), .reset(reset), .tone_in(tin_b), .enable(en_b),
        .period(period_b), .period_valid(valid_b), .timeout(tmo_b)
    );

    always #5 clock = ~clock;

    // Count valid pulses, valid-high cycles and spacing between pulses
    always @(posedge clock) begin
        #1;
        cyc = cyc + 1;
        if (valid_a) a_high = a_high + 1;
        if (valid_a && !a_prev) begin
            a_edges = a_edges + 1;
            a_gap   = cyc - a_last;
            a_last  = cyc;
        end
        if (valid_b && !b_prev) b_edges = b_edges + 1;
        a_prev = valid_a;
        b_prev = valid_b;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // n square-wave cycles of hi clocks high then lo clocks low on A or B
    task automatic run(input bit sel_b, input int hi, input int lo, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_b) tin_b = 1'b1; else tin_a = 1'b1;
            repeat (hi) @(negedge clock);
            if (sel_b) tin_b = 1'b0; else tin_a = 1'b0;
            repeat (lo) @(negedge clock);
        end
    endtask

    initial begin
        int e0, h0;

        // Reset state
        #12;
        check("rst_period_a", 32'(period_a), 0);
        check("rst_valid_a",  32'(valid_a),  0);
        check("rst_tmo_a",    32'(tmo_a),    0);
        check("rst_period_b", 32'(period_b), 0);
        check("rst_tmo_b",    32'(tmo_b),    0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);

        // P=10: four rises -> three pulses of period 10, 10 cycles apart
        en_a = 1'b1;
        run(1'b0, 5, 5, 4);
        check("p10_pulses",  32'(a_edges), 3);
        check("p10_single",  32'(a_high),  3);
        check("p10_period",  32'(period_a), 10);
        check("p10_gap",     32'(a_gap),   10);
        check("p10_tmo",     32'(tmo_a),   0);

        // Latency: tone high before edge k -> valid during cycle after k+2
        tin_a = 1'b1;
        @(negedge clock); check("lat_k",   32'(valid_a), 0);
        @(negedge clock); check("lat_k1",  32'(valid_a), 0);
        @(negedge clock); check("lat_k2",  32'(valid_a), 1);
        @(negedge clock); check("lat_k3",  32'(valid_a), 0);
        check("lat_period", 32'(period_a), 10);
        @(negedge clock);
        tin_a = 1'b0;
        repeat (5) @(negedge clock);

        // Disable: idle outputs, period holds
        en_a = 1'b0;
        repeat (3) @(negedge clock);
        check("dis_valid",  32'(valid_a), 0);
        check("dis_tmo",    32'(tmo_a),   0);
        check("dis_period", 32'(period_a), 10);

        // P=2: ten rises -> nine pulses, period 2
        e0 = a_edges; h0 = a_high;
        en_a = 1'b1;
        run(1'b0, 1, 1, 10);
        repeat (4) @(negedge clock);
        check("p2_pulses", 32'(a_edges - e0), 9);
        check("p2_single", 32'(a_high - h0),  9);
        check("p2_period", 32'(period_a), 2);
        check("p2_gap",    32'(a_gap),    2);

        // Re-arm at P=8, then drop enable in the cycle the rise is seen
        en_a = 1'b0;
        @(negedge clock);
        en_a = 1'b1;
        e0 = a_edges;
        run(1'b0, 4, 4, 3);
        check("p8_pulses", 32'(a_edges - e0), 2);
        check("p8_period", 32'(period_a), 8);
        e0 = a_edges;
        tin_a = 1'b1;
        @(negedge clock);
        @(negedge clock);
        en_a = 1'b0;
        @(negedge clock);
        check("enrise_valid",  32'(valid_a), 0);
        check("enrise_period", 32'(period_a), 8);
        @(negedge clock);
        tin_a = 1'b0;
        repeat (4) @(negedge clock);
        check("enrise_pulses", 32'(a_edges - e0), 0);
        en_a = 1'b1;
        run(1'b0, 3, 3, 3);
        check("reen_pulses", 32'(a_edges - e0), 2);
        check("reen_period", 32'(period_a), 6);

        // Asynchronous reset mid-count, then P=10 rearm
        repeat (3) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("arst_period", 32'(period_a), 0);
        check("arst_valid",  32'(valid_a),  0);
        check("arst_tmo",    32'(tmo_a),    0);
        @(negedge clock);
        reset = 1'b1;
        e0 = a_edges;
        run(1'b0, 5, 5, 2);
        check("arst_pulses", 32'(a_edges - e0), 1);
        check("arst_p10",    32'(period_a), 10);

        // CNT_WIDTH=4: one rise then low -> timeout one edge after count 15
        en_b = 1'b1;
        tin_b = 1'b1;
        for (int m = 1; m <= 18; m++) begin
            @(negedge clock);
            if (m == 2) tin_b = 1'b0;
            if (m == 17) check("tmo_before", 32'(tmo_b), 0);
            if (m == 18) check("tmo_set",    32'(tmo_b), 1);
        end
        repeat (3) @(negedge clock);
        check("tmo_pulses", 32'(b_edges), 0);
        check("tmo_period", 32'(period_b), 0);
        run(1'b1, 5, 5, 1);
        check("tmo_arm_sticky", 32'(tmo_b), 1);
        check("tmo_arm_pulses", 32'(b_edges), 0);
        run(1'b1, 5, 5, 1);
        check("tmo_clear",     32'(tmo_b), 0);
        check("tmo_rec_pulse", 32'(b_edges), 1);
        check("tmo_rec_period", 32'(period_b), 10);

        // P=15 on a 4-bit counter: rise at all-ones is a measurement
        run(1'b1, 8, 7, 3);
        check("p15_pulses", 32'(b_edges), 4);
        check("p15_period", 32'(period_b), 15);
        check("p15_tmo",    32'(tmo_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tone_period_meter.md
TONE_PERIOD_METER -- requirements
Module: tone_period_meter

Interface
REQ-001 Parameter CNT_WIDTH, default 20, sets the width of the period counter and the period output.
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of synchronizer flops on tone_in (legal values 2..3).
REQ-003 Port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 Port tone_in, input, 1 bit: asynchronous square wave to be measured (e.g. divided tone clock).
REQ-006 Port enable, input, 1 bit, synchronous: high = measure, low = idle.
REQ-007 Port period, output, CNT_WIDTH bits: last measured rising-edge-to-rising-edge period in clock cycles.
REQ-008 Port period_valid, output, 1 bit: single-cycle pulse marking a new period value.
REQ-009 Port timeout, output, 1 bit: sticky flag, counter saturated with no edge.

Function
REQ-010 tone_in SHALL pass through SYNC_STAGES flops, then one history flop; rise = sync_out & ~history.
REQ-011 The FSM SHALL have states IDLE, ARM and MEASURE, encoded in registers.
REQ-012 IDLE: counter = 0; go to ARM when enable = 1.
REQ-013 ARM: on rise, counter <= 1 and go to MEASURE; otherwise hold.
REQ-014 MEASURE, no rise and counter < all-ones: counter increments by 1.
REQ-015 MEASURE on rise: period <= counter, period_valid = 1 for exactly one cycle, timeout <= 0, counter <= 1, stay in MEASURE.
REQ-016 MEASURE, counter = all-ones and no rise: timeout <= 1, period unchanged, no pulse, counter <= 0, go to ARM.
REQ-017 Rise coinciding with counter = all-ones SHALL be treated as a measurement per REQ-015 (period = 2^CNT_WIDTH-1), not a timeout.
REQ-018 For a steady input of P clocks per cycle (2 <= P <= 2^CNT_WIDTH-1), every period output after the first SHALL equal P exactly.
REQ-019 The first rise after leaving IDLE or a timeout SHALL only arm the meter; it SHALL NOT produce period_valid.
REQ-020 Latency: tone_in rising, first sampled high at clock edge k, SHALL give period_valid high during the cycle after edge k+SYNC_STAGES.
REQ-021 enable = 0 in any state SHALL go to IDLE on the next edge with counter = 0, timeout = 0 and period_valid = 0; period holds its last value.
REQ-022 enable deasserted in the same cycle as a rise SHALL take priority, with no pulse and period unchanged.
REQ-023 Period arithmetic SHALL be unsigned CNT_WIDTH-bit; the counter SHALL never wrap.
REQ-024 All outputs SHALL be driven directly from flops, with no combinational path from input to output.

Reset
REQ-025 reset = 0 SHALL immediately, without a clock, force state IDLE, counter 0, period 0, period_valid 0, timeout 0 and clear all synchronizer and history flops.
REQ-026 Reset asserted mid-measurement SHALL discard the partial count; after release the meter SHALL rearm per REQ-019.
REQ-027 Reset release SHALL be taken synchronous to clock by the integrating level; the block adds no reset synchronizer.

Verification
REQ-028 Defaults, enable = 1, tone_in period 10 clocks (5 high / 5 low) -> first rise arms only; each following rise gives period = 10 with one-cycle period_valid, pulses 10 cycles apart.
REQ-029 tone_in toggling every clock (P = 2) -> period = 2 and a period_valid pulse every 2 cycles.
REQ-030 CNT_WIDTH = 4, one rise then tone_in held low -> timeout = 1 after the counter reaches 15, no pulse, period unchanged; next two rises -> timeout = 0 and a valid period.
REQ-031 Rise at counter = 15 (CNT_WIDTH = 4, P = 15) -> period = 15 and period_valid, timeout stays 0.
REQ-032 enable dropped in the cycle of a rise -> no pulse, period holds; re-enable -> first rise arms only.
REQ-033 reset pulsed low between clock edges mid-count -> all outputs 0 immediately; after release, P = 10 input -> first valid is period = 10 on the second rise.
